// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the slave-memory bridge.
//   - htrans, hresp and hsize bus encodings
//   - ahb_slv_st_t: data-phase state of the slave FSM
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_ISS,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_slv_st_t;

endpackage

// File: rtl/ahb_lane_dec.sv
// Combinational byte-lane decoder for 32-bit little-endian AHB transfers.
//   hsize   in   transfer size (0 byte, 1 half, 2 word, >2 illegal)
//   addr_lo in   haddr[1:0]
//   be      out  byte enables (all zero for an illegal transfer)
//   illegal out  size too large or address misaligned for the size
module ahb_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       illegal
);

  always_comb begin
    be      = '0;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[0]) illegal = 1'b1;
        else            be      = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        if (addr_lo != 2'b00) illegal = 1'b1;
        else                  be      = '1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave mapping one router slave port onto a synchronous
// single-port 32-bit memory, with wait_c programmable wait states and
// size/alignment checking (illegal transfers get a two-cycle ERROR).
//   hclk, hresetn        clock, synchronous active-low reset
//   hsel, hreadyin       slave select and bus-level hready
//   haddr, hwrite, htrans, hsize, hburst, hwdata   AHB request
//   hrdata, hresp, hready                          AHB response
//   mem_addr, mem_wdata, mem_be, mem_we, mem_re    memory request
//   mem_rdata            memory read data, valid the cycle after mem_re
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned addr_w = 10,
  parameter int unsigned wait_c = 0
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic              hreadyin,
  input  logic [31:0]       haddr,
  input  logic [31:0]       hwdata,
  input  logic              hwrite,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  output logic [31:0]       hrdata,
  output logic [1:0]        hresp,
  output logic              hready,
  output logic [addr_w-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  ahb_slv_st_t state;
  logic [3:0]  wcnt;
  logic        cap_write;
  logic        rd_phase;
  logic        accept;
  logic        reg_we;
  logic [3:0]  lane_be;
  logic        illegal;
  logic        unused_ok;

  // Upper address bits are decoded by the router; burst type is irrelevant
  // because every beat is treated as a single transfer.
  assign unused_ok = ^{hburst, haddr[31:addr_w+2], htrans[0]};

  assign accept = hsel & hreadyin & hready & htrans[1];
  assign reg_we = accept;

  ahb_lane_dec u_lane_dec (
    .hsize   (hsize),
    .addr_lo (haddr[1:0]),
    .be      (lane_be),
    .illegal (illegal)
  );

  // Address-phase capture. The decoded byte enables are stored instead of
  // hsize, so mem_be is already valid when the strobe fires.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      mem_addr  <= '0;
      mem_be    <= '0;
      cap_write <= 1'b0;
    end else if (reg_we) begin
      mem_addr  <= haddr[addr_w+1:2];
      mem_be    <= lane_be;
      cap_write <= hwrite;
    end
  end

  assign mem_wdata = hwdata;

  // Memory read data is only valid in the cycle after mem_re, so it is
  // passed through combinationally, gated by the registered read-DATA flag.
  assign hrdata = rd_phase ? mem_rdata : '0;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      hready   <= 1'b1;
      hresp    <= HRESP_OKAY;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      rd_phase <= 1'b0;
      wcnt     <= '0;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      rd_phase <= 1'b0;
      hresp    <= HRESP_OKAY;
      case (state)
        ST_WAIT: begin
          if (wcnt == 4'd1) begin
            if (cap_write) begin
              state  <= ST_DATA;
              hready <= 1'b1;
              mem_we <= 1'b1;
            end else begin
              state  <= ST_RD_ISS;
              mem_re <= 1'b1;
            end
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        ST_RD_ISS: begin
          state    <= ST_DATA;
          hready   <= 1'b1;
          rd_phase <= 1'b1;
        end
        ST_ERR1: begin
          state  <= ST_ERR2;
          hready <= 1'b1;
          hresp  <= HRESP_ERROR;
        end
        // IDLE, DATA and ERR2 all drive hready=1, so a pipelined address
        // phase may be accepted from any of them.
        default: begin
          if (accept) begin
            if (illegal) begin
              state  <= ST_ERR1;
              hready <= 1'b0;
              hresp  <= HRESP_ERROR;
            end else if (wait_c != 0) begin
              state  <= ST_WAIT;
              wcnt   <= 4'(wait_c);
              hready <= 1'b0;
            end else if (hwrite) begin
              state  <= ST_DATA;
              hready <= 1'b1;
              mem_we <= 1'b1;
            end else begin
              state  <= ST_RD_ISS;
              hready <= 1'b0;
              mem_re <= 1'b1;
            end
          end else begin
            state  <= ST_IDLE;
            hready <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed testbench for ahb_slave_mem: one instance with no wait states
// (dut0) and one with two wait states (dut2), each backed by its own
// synchronous memory model. Bus signals are shared; hsel picks the target.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel2, hreadyin;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;

  logic [31:0] hrdata0, hrdata2, mem_wdata0, mem_wdata2, mem_rdata0, mem_rdata2;
  logic [1:0]  hresp0, hresp2;
  logic        hready0, hready2, mem_we0, mem_we2, mem_re0, mem_re2;
  logic [9:0]  mem_addr0, mem_addr2;
  logic [3:0]  mem_be0, mem_be2;

  logic        mem_clr;
  logic [31:0] mem0 [1024];
  logic [31:0] mem2 [1024];

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.addr_w(10), .wait_c(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .hreadyin(hreadyin),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hrdata(hrdata0), .hresp(hresp0),
    .hready(hready0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_be(mem_be0), .mem_we(mem_we0), .mem_re(mem_re0), .mem_rdata(mem_rdata0)
  );

  ahb_slave_mem #(.addr_w(10), .wait_c(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .hreadyin(hreadyin),
    .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hburst(hburst), .hrdata(hrdata2), .hresp(hresp2),
    .hready(hready2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_be(mem_be2), .mem_we(mem_we2), .mem_re(mem_re2), .mem_rdata(mem_rdata2)
  );

  always @(posedge hclk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= '0;
        mem2[i] <= '0;
      end
      mem_rdata0 <= '0;
      mem_rdata2 <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we0 && mem_be0[b]) mem0[mem_addr0][8*b +: 8] <= mem_wdata0[8*b +: 8];
        if (mem_we2 && mem_be2[b]) mem2[mem_addr2][8*b +: 8] <= mem_wdata2[8*b +: 8];
      end
      if (mem_re0) mem_rdata0 <= mem0[mem_addr0];
      if (mem_re2) mem_rdata2 <= mem2[mem_addr2];
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic sample();
    @(negedge hclk);
  endtask

  task automatic bus_idle();
    hsel0 = 1'b0; hsel2 = 1'b0; htrans = 2'd0; hwrite = 1'b0;
    haddr = '0; hsize = 3'd2;
  endtask

  task automatic addr_phase(input logic to2, input logic [31:0] a,
                            input logic w, input logic [2:0] sz);
    hsel0 = !to2; hsel2 = to2; haddr = a; hwrite = w; hsize = sz; htrans = 2'd2;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; mem_clr = 1'b1; hreadyin = 1'b1; hwdata = '0; hburst = '0;
    bus_idle();
    repeat (3) tick();
    mem_clr = 1'b0;
    sample();
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL rst_hready: got %b expected 1", hready0); end
    checks++; if (hresp0 !== 2'd0) begin errors++; $display("FAIL rst_hresp: got %0d expected 0", hresp0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h expected 0", hrdata0); end
    checks++; if ({mem_we0, mem_re0} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b expected 00", {mem_we0, mem_re0}); end
    checks++; if (mem_be0 !== 4'h0) begin errors++; $display("FAIL rst_be: got %h expected 0", mem_be0); end
    checks++; if (mem_addr0 !== 10'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_addr0); end
    checks++; if (hready2 !== 1'b1) begin errors++; $display("FAIL rst_hready2: got %b expected 1", hready2); end
    tick();
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_word_wr_rd();
    addr_phase(1'b0, 32'h10, 1'b1, 3'd2);
    sample();
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL t1_addr_rdy: got %b expected 1", hready0); end
    tick();
    bus_idle(); hwdata = 32'hDEADBEEF;
    sample();
    checks++; if (mem_we0 !== 1'b1) begin errors++; $display("FAIL t1_we: got %b expected 1", mem_we0); end
    checks++; if (mem_be0 !== 4'hF) begin errors++; $display("FAIL t1_be: got %h expected f", mem_be0); end
    checks++; if (mem_addr0 !== 10'd4) begin errors++; $display("FAIL t1_addr: got %h expected 4", mem_addr0); end
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL t1_wr_rdy: got %b expected 1", hready0); end
    checks++; if (mem_wdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_wdata: got %h expected deadbeef", mem_wdata0); end
    tick();
    sample();
    checks++; if ({mem_we0, hready0} !== 2'b01) begin errors++; $display("FAIL t1_we_once: got we,rdy=%b expected 01", {mem_we0, hready0}); end
    addr_phase(1'b0, 32'h10, 1'b0, 3'd2);
    tick();
    bus_idle();
    sample();
    checks++; if ({hready0, mem_re0} !== 2'b01) begin errors++; $display("FAIL t1_rd_iss: got rdy,re=%b expected 01", {hready0, mem_re0}); end
    tick();
    sample();
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL t1_rd_rdy: got %b expected 1", hready0); end
    checks++; if (hrdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rdata: got %h expected deadbeef", hrdata0); end
    checks++; if (hresp0 !== 2'd0) begin errors++; $display("FAIL t1_rd_resp: got %0d expected 0", hresp0); end
    tick();
    sample();
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL t1_rdata_idle: got %h expected 0", hrdata0); end
    tick();
  endtask

  task automatic test_wait_states();
    int low;
    logic [3:0] be_at_re;
    addr_phase(1'b1, 32'h13, 1'b1, 3'd0);
    tick();
    bus_idle(); hwdata = 32'hAB000000;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (hready2) break;
      low++;
      tick();
    end
    checks++; if (low !== 2) begin errors++; $display("FAIL t2_wr_wait: got %0d expected 2", low); end
    checks++; if (mem_we2 !== 1'b1) begin errors++; $display("FAIL t2_we: got %b expected 1", mem_we2); end
    checks++; if (mem_be2 !== 4'b1000) begin errors++; $display("FAIL t2_wr_be: got %b expected 1000", mem_be2); end
    checks++; if (mem_addr2 !== 10'd4) begin errors++; $display("FAIL t2_addr: got %h expected 4", mem_addr2); end
    tick();
    addr_phase(1'b1, 32'h12, 1'b0, 3'd1);
    tick();
    bus_idle();
    low = 0; be_at_re = 4'h0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (hready2) break;
      if (mem_re2) be_at_re = mem_be2;
      low++;
      tick();
    end
    checks++; if (low !== 3) begin errors++; $display("FAIL t2_rd_wait: got %0d expected 3", low); end
    checks++; if (be_at_re !== 4'b1100) begin errors++; $display("FAIL t2_rd_be: got %b expected 1100", be_at_re); end
    checks++; if (hrdata2 !== 32'hAB000000) begin errors++; $display("FAIL t2_rdata: got %h expected ab000000", hrdata2); end
    checks++; if (hresp2 !== 2'd0) begin errors++; $display("FAIL t2_resp: got %0d expected 0", hresp2); end
    tick();
  endtask

  task automatic test_error();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) addr_phase(1'b0, 32'h02, 1'b0, 3'd2);
      else        addr_phase(1'b0, 32'h10, 1'b1, 3'd3);
      tick();
      bus_idle();
      sample();
      checks++; if ({hready0, hresp0} !== 3'b001) begin errors++; $display("FAIL t3_err1_%0d: got rdy,resp=%b expected 001", k, {hready0, hresp0}); end
      checks++; if ({mem_we0, mem_re0} !== 2'b00) begin errors++; $display("FAIL t3_err1_strb_%0d: got %b expected 00", k, {mem_we0, mem_re0}); end
      tick();
      sample();
      checks++; if ({hready0, hresp0} !== 3'b101) begin errors++; $display("FAIL t3_err2_%0d: got rdy,resp=%b expected 101", k, {hready0, hresp0}); end
      checks++; if ({mem_we0, mem_re0} !== 2'b00) begin errors++; $display("FAIL t3_err2_strb_%0d: got %b expected 00", k, {mem_we0, mem_re0}); end
      tick();
      sample();
      checks++; if ({hready0, hresp0} !== 3'b100) begin errors++; $display("FAIL t3_after_%0d: got rdy,resp=%b expected 100", k, {hready0, hresp0}); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    addr_phase(1'b0, 32'h20, 1'b1, 3'd2);
    tick();
    hwdata = 32'h12345678;
    addr_phase(1'b0, 32'h20, 1'b0, 3'd2);
    sample();
    checks++; if ({mem_we0, mem_re0} !== 2'b10) begin errors++; $display("FAIL t4_wr_data: got we,re=%b expected 10", {mem_we0, mem_re0}); end
    tick();
    bus_idle();
    sample();
    checks++; if ({mem_we0, mem_re0, hready0} !== 3'b010) begin errors++; $display("FAIL t4_rd_iss: got we,re,rdy=%b expected 010", {mem_we0, mem_re0, hready0}); end
    tick();
    sample();
    checks++; if (hrdata0 !== 32'h12345678) begin errors++; $display("FAIL t4_rdata: got %h expected 12345678", hrdata0); end
    checks++; if ({mem_we0, mem_re0, hready0} !== 3'b001) begin errors++; $display("FAIL t4_rd_data: got we,re,rdy=%b expected 001", {mem_we0, mem_re0, hready0}); end
    tick();
  endtask

  task automatic test_idle_busy();
    logic [1:0] tr [3];
    logic       hr [3];
    tr[0] = 2'd1; hr[0] = 1'b1;
    tr[1] = 2'd0; hr[1] = 1'b1;
    tr[2] = 2'd2; hr[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hsel0 = 1'b1; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
      htrans = tr[k]; hreadyin = hr[k];
      tick();
      bus_idle(); hreadyin = 1'b1;
      sample();
      checks++; if ({mem_we0, mem_re0} !== 2'b00) begin errors++; $display("FAIL t5_strobes_%0d: got %b expected 00", k, {mem_we0, mem_re0}); end
      checks++; if ({hready0, hresp0} !== 3'b100) begin errors++; $display("FAIL t5_resp_%0d: got rdy,resp=%b expected 100", k, {hready0, hresp0}); end
      tick();
    end
  endtask

  task automatic test_reset_midread();
    addr_phase(1'b0, 32'h10, 1'b0, 3'd2);
    tick();
    bus_idle();
    sample();
    checks++; if (mem_re0 !== 1'b1) begin errors++; $display("FAIL t6_re: got %b expected 1", mem_re0); end
    hresetn = 1'b0;
    tick();
    sample();
    checks++; if ({hready0, mem_re0} !== 2'b10) begin errors++; $display("FAIL t6_rst_rdy_re: got %b expected 10", {hready0, mem_re0}); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL t6_rst_rdata: got %h expected 0", hrdata0); end
    hresetn = 1'b1;
    tick();
    addr_phase(1'b0, 32'h10, 1'b0, 3'd2);
    tick();
    bus_idle();
    sample();
    checks++; if ({hready0, mem_re0} !== 2'b01) begin errors++; $display("FAIL t6_re2: got rdy,re=%b expected 01", {hready0, mem_re0}); end
    tick();
    sample();
    checks++; if (hrdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL t6_rdata: got %h expected deadbeef", hrdata0); end
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL t6_rdy: got %b expected 1", hready0); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_wr_rd();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_idle_busy();
    test_reset_midread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
